// File: rtl/scene_query_arbiter.sv
// scene_query_arbiter: shares one sceneQuery SDF pipeline among N_LANES
// ray-march lanes. The arbiter issues at most one query per cycle, round-robin
// among lanes requesting the current object. It tags each query with its lane
// in an in-order FIFO and routes each returned distance back to that lane.
// The object select changes only once the pipeline has fully drained.
module scene_query_arbiter #(
    parameter int N_LANES      = 4,
    parameter int MAX_INFLIGHT = 16,
    parameter int MAX_BURST    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_LANES-1:0]              req_valid,
    output logic [N_LANES-1:0]              req_ready,
    input  logic [N_LANES*96-1:0]           req_pos,
    input  logic [N_LANES-1:0]              req_obj,
    output logic                            sq_valid_in,
    output logic [95:0]                     sq_pos,
    output logic                            sq_obj_sel,
    input  logic [31:0]                     sq_dist,
    input  logic                            sq_valid_out,
    output logic                            resp_valid,
    output logic [$clog2(N_LANES)-1:0]      resp_lane,
    output logic [31:0]                     resp_dist,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_orphan
);

    localparam int LANE_W  = $clog2(N_LANES);
    localparam int SCAN_W  = LANE_W + 1;
    localparam int PTR_W   = $clog2(MAX_INFLIGHT);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(N_LANES - 1);
    localparam logic [SCAN_W-1:0]  LANE_CNT  = SCAN_W'(N_LANES);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(MAX_INFLIGHT - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(MAX_INFLIGHT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic {ISSUE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 cur_obj;
    logic [LANE_W-1:0]    rr_ptr;
    logic [BURST_W-1:0]   burst;
    logic [LANE_W-1:0]    fifo_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;

    logic [95:0]          pos_arr [N_LANES];
    logic [N_LANES-1:0]   eligible;
    logic                 other_pend;
    logic                 switch_req;
    logic                 fifo_full;
    logic                 grant_hit;
    logic [LANE_W-1:0]    grant_idx;
    logic [SCAN_W-1:0]    scan;
    logic                 issue;
    logic                 pop;

    for (genvar g = 0; g < N_LANES; g++) begin : g_unpack
        assign pos_arr[g] = req_pos[g*96 +: 96];
    end

    assign eligible   = req_valid & ~(req_obj ^ {N_LANES{cur_obj}});
    assign other_pend = |(req_valid & (req_obj ^ {N_LANES{cur_obj}}));
    assign switch_req = other_pend && (!grant_hit || burst == BURST_MAX);
    assign fifo_full  = (inflight == CNT_FULL);
    assign pop        = sq_valid_out && (inflight != '0);
    assign sq_obj_sel = cur_obj;

    // Round-robin scan: first eligible lane at or after the rr pointer
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            scan = {1'b0, rr_ptr} + SCAN_W'(i);
            if (scan >= LANE_CNT) scan = scan - LANE_CNT;
            if (!grant_hit && eligible[scan[LANE_W-1:0]]) begin
                grant_hit = 1'b1;
                grant_idx = scan[LANE_W-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ISSUE;
        else      state_q <= state_d;
    end

    // FSM next state: leave ISSUE to switch objects, leave DRAIN once empty
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISSUE: if (switch_req) state_d = DRAIN;
            DRAIN: if (inflight == '0) state_d = ISSUE;
        endcase
    end

    // FSM outputs: one-hot grant; forced low while reset is asserted
    always_comb begin
        issue     = rst && (state_q == ISSUE) && !switch_req && !fifo_full && grant_hit;
        req_ready = '0;
        if (issue) req_ready[grant_idx] = 1'b1;
    end

    // Object select, rr pointer and burst counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_obj <= 1'b0;
            rr_ptr  <= '0;
            burst   <= '0;
        end else if (state_q == DRAIN && inflight == '0) begin
            cur_obj <= ~cur_obj;
            burst   <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == LANE_LAST) ? '0 : grant_idx + LANE_W'(1);
            if (burst != BURST_MAX) burst <= burst + BURST_W'(1);
        end
    end

    // Registered issue to the sceneQuery pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_valid_in <= 1'b0;
            sq_pos      <= '0;
        end else begin
            sq_valid_in <= issue;
            if (issue) sq_pos <= pos_arr[grant_idx];
        end
    end

    // Tag FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (issue) fifo_mem[wr_ptr] <= grant_idx;
    end

    // Tag FIFO pointers and outstanding count; issue+return leaves count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (issue) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            if (issue && !pop)      inflight <= inflight + CNT_W'(1);
            else if (!issue && pop) inflight <= inflight - CNT_W'(1);
        end
    end

    // Return path: route result to the head tag; flag returns with no tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_lane  <= '0;
            resp_dist  <= '0;
            err_orphan <= 1'b0;
        end else begin
            resp_valid <= pop;
            if (pop) begin
                resp_lane <= fifo_mem[rd_ptr];
                resp_dist <= sq_dist;
            end
            if (sq_valid_out && inflight == '0) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scene_query_arbiter.sv
// Testbench for scene_query_arbiter with a behavioural sceneQuery model
// (sphere latency 4, cube latency 6, optional output stall).
module tb_scene_query_arbiter;

    localparam int LAT_S = 4;
    localparam int LAT_C = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [383:0] req_pos;
    logic [3:0]   req_obj;
    logic         sq_valid_in;
    logic [95:0]  sq_pos;
    logic         sq_obj_sel;
    logic [31:0]  sq_dist = '0;
    logic         sq_valid_out = 1'b0;
    logic         resp_valid;
    logic [1:0]   resp_lane;
    logic [31:0]  resp_dist;
    logic [4:0]   inflight;
    logic         err_orphan;

    scene_query_arbiter #(
        .N_LANES(4),
        .MAX_INFLIGHT(16),
        .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pos(req_pos), .req_obj(req_obj),
        .sq_valid_in(sq_valid_in), .sq_pos(sq_pos), .sq_obj_sel(sq_obj_sel),
        .sq_dist(sq_dist), .sq_valid_out(sq_valid_out),
        .resp_valid(resp_valid), .resp_lane(resp_lane), .resp_dist(resp_dist),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [95:0] pos_of(input int l);
        return {32'h0, 32'(l * 7), 32'(l + 1) << 24};
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int j = 0; j < 4; j++) if (v[j]) return j;
        return 0;
    endfunction

    // sceneQuery model: samples issues on the falling edge, returns in order
    typedef struct { logic [95:0] pos; logic obj; int due; } q_item_t;
    q_item_t pipe_q[$];
    q_item_t head_item;
    int      mcyc = 0;
    logic    stall = 1'b0;
    logic    inject_orphan = 1'b0;

    always @(negedge clk) begin
        mcyc++;
        sq_valid_out = 1'b0;
        if (!rst) begin
            pipe_q.delete();
        end else begin
            if (sq_valid_in)
                pipe_q.push_back('{sq_pos, sq_obj_sel, mcyc + (sq_obj_sel ? LAT_C : LAT_S)});
            if (inject_orphan) begin
                sq_valid_out = 1'b1;
                sq_dist      = 32'hDEAD_BEEF;
            end else if (!stall && pipe_q.size() != 0 && pipe_q[0].due <= mcyc) begin
                head_item    = pipe_q.pop_front();
                sq_valid_out = 1'b1;
                sq_dist      = head_item.pos[31:0] - (head_item.obj ? 32'h0080_0000 : 32'h0100_0000);
            end
        end
    end

    // Response monitor
    int          obs_lane[$];
    logic [31:0] obs_dist[$];
    int          obs_cyc[$];
    int          mon_cyc = 0;

    always @(negedge clk) begin
        mon_cyc++;
        if (resp_valid) begin
            obs_lane.push_back(int'(resp_lane));
            obs_dist.push_back(resp_dist);
            obs_cyc.push_back(mon_cyc);
        end
    end

    task automatic wait_resp(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (obs_lane.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check({name, " resp count"}, 96'(obs_lane.size()), 96'(n));
    endtask

    task automatic apply_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        req_obj = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] obj;
        logic [3:0] exp_ready;
        logic [4:0] exp_inflight;
    } vec_t;
    vec_t vecs[8];

    int         base;
    int         ng;
    int         flip_resp;
    int         lane2_infl;
    logic       lane2_sel;
    logic [3:0] gq[$];
    int         tbl_lanes[6] = '{0, 1, 3, 1, 0, 0};
    logic [3:0] burst_exp[4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rr pointer starts at 0; stall keeps every grant outstanding
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 5'd0};
        vecs[1] = '{4'b1111, 4'b0000, 4'b0001, 5'd1};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0010, 5'd2};
        vecs[3] = '{4'b1001, 4'b0000, 4'b1000, 5'd3};
        vecs[4] = '{4'b0110, 4'b0000, 4'b0010, 5'd4};
        vecs[5] = '{4'b0011, 4'b0000, 4'b0001, 5'd5};
        vecs[6] = '{4'b0001, 4'b0000, 4'b0001, 5'd6};
        vecs[7] = '{4'b0110, 4'b0100, 4'b0000, 5'd6};   // burst at limit, cube pending

        for (int l = 0; l < 4; l++) req_pos[l*96 +: 96] = pos_of(l);
        rst = 1'b0;
        req_valid = 4'b1111;
        req_obj = '0;

        // Reset state, with requests present
        repeat (2) @(negedge clk);
        #1;
        check("rst req_ready",   96'(req_ready),   96'(0));
        check("rst sq_valid_in", 96'(sq_valid_in), 96'(0));
        check("rst sq_obj_sel",  96'(sq_obj_sel),  96'(0));
        check("rst resp_valid",  96'(resp_valid),  96'(0));
        check("rst inflight",    96'(inflight),    96'(0));
        check("rst err_orphan",  96'(err_orphan),  96'(0));
        req_valid = '0;
        @(negedge clk); #1 rst = 1'b1;

        // Single lane 0 sphere query
        base = obs_lane.size();
        @(negedge clk); #1;
        req_valid = 4'b0001;
        #1 check("single ready", 96'(req_ready), 96'(4'b0001));
        @(posedge clk); #1;
        check("single sq_valid_in", 96'(sq_valid_in), 96'(1));
        check("single sq_pos",      sq_pos,           pos_of(0));
        @(negedge clk); #1 req_valid = '0;
        wait_resp("single", base + 1, 20);
        check("single resp_lane", 96'(obs_lane[base]), 96'(0));
        check("single resp_dist", 96'(obs_dist[base]), 96'(32'h0000_0000));
        check("single inflight",  96'(inflight),       96'(0));

        // Table-driven round-robin grants with the output stalled
        apply_reset();
        stall = 1'b1;
        base = obs_lane.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            req_valid = vecs[i].valid;
            req_obj = vecs[i].obj;
            #1 check($sformatf("tbl%0d ready", i), 96'(req_ready), 96'(vecs[i].exp_ready));
            @(posedge clk); #1;
            check($sformatf("tbl%0d sq_valid_in", i), 96'(sq_valid_in), 96'(|vecs[i].exp_ready));
            if (vecs[i].exp_ready != 4'b0000)
                check($sformatf("tbl%0d sq_pos", i), sq_pos, pos_of(oh_idx(vecs[i].exp_ready)));
            check($sformatf("tbl%0d inflight", i), 96'(inflight), 96'(vecs[i].exp_inflight));
        end
        @(negedge clk); #1;
        req_valid = '0;
        req_obj = '0;
        stall = 1'b0;
        wait_resp("tbl", base + 6, 40);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("tbl resp%0d lane", k), 96'(obs_lane[base+k]), 96'(tbl_lanes[k]));
            check($sformatf("tbl resp%0d dist", k), 96'(obs_dist[base+k]), 96'(32'(tbl_lanes[k]) << 24));
        end

        // All four lanes continuously on the sphere
        apply_reset();
        base = obs_lane.size();
        @(negedge clk); #1 req_valid = 4'b1111;
        repeat (12) @(negedge clk);
        #1 req_valid = '0;
        wait_resp("rr4", base + 12, 40);
        for (int k = 0; k < 12; k++)
            check($sformatf("rr4 resp%0d lane", k), 96'(obs_lane[base+k]), 96'(k % 4));
        check("rr4 no gaps", 96'(obs_cyc[base+11] - obs_cyc[base]), 96'(11));

        // Burst limit forces a drain and switch to the cube
        apply_reset();
        base = obs_lane.size();
        flip_resp = -1;
        lane2_infl = -1;
        lane2_sel = 1'b0;
        gq.delete();
        @(negedge clk); #1;
        req_valid = 4'b0111;
        req_obj = 4'b0100;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (sq_obj_sel && flip_resp < 0) flip_resp = obs_lane.size() - base;
            if (req_ready != 4'b0000) begin
                gq.push_back(req_ready);
                if (req_ready == 4'b0100) begin
                    lane2_sel = sq_obj_sel;
                    lane2_infl = int'(inflight);
                    break;
                end
            end
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        req_valid = '0;
        req_obj = '0;
        check("burst grant count", 96'(gq.size()), 96'(5));
        for (int k = 0; k < 4; k++)
            check($sformatf("burst grant%0d", k), 96'(gq[k]), 96'(burst_exp[k]));
        check("burst cube grant",      96'(gq[4]),      96'(4'b0100));
        check("burst flip after resp", 96'(flip_resp),  96'(4));
        check("burst cube obj_sel",    96'(lane2_sel),  96'(1));
        check("burst cube inflight",   96'(lane2_infl), 96'(0));
        wait_resp("burst", base + 5, 40);
        check("burst cube lane", 96'(obs_lane[base+4]), 96'(2));
        check("burst cube dist", 96'(obs_dist[base+4]), 96'(32'h0280_0000));

        // Tag FIFO full, then release returns one at a time
        apply_reset();
        stall = 1'b1;
        base = obs_lane.size();
        ng = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != 4'b0000) ng++;
            @(negedge clk); #1;
        end
        check("full grants",   96'(ng),        96'(16));
        check("full inflight", 96'(inflight),  96'(16));
        check("full ready",    96'(req_ready), 96'(0));
        stall = 1'b0;
        @(negedge clk); #1;
        check("full pop-cycle ready",    96'(req_ready), 96'(0));
        check("full pop-cycle inflight", 96'(inflight),  96'(16));
        @(negedge clk); #1;
        check("after pop inflight", 96'(inflight),  96'(15));
        check("after pop ready",    96'(req_ready), 96'(4'b0001));
        stall = 1'b1;
        @(negedge clk); #1;
        check("issue+ret inflight",    96'(inflight),    96'(15));
        check("issue+ret sq_valid_in", 96'(sq_valid_in), 96'(1));
        req_valid = '0;
        stall = 1'b0;
        wait_resp("full", base + 17, 80);
        check("full drained inflight", 96'(inflight), 96'(0));

        // Orphan return with nothing in flight
        base = obs_lane.size();
        check("orphan pre", 96'(err_orphan), 96'(0));
        @(negedge clk); #1 inject_orphan = 1'b1;
        @(negedge clk); #1 inject_orphan = 1'b0;
        @(negedge clk); #1;
        check("orphan flag",     96'(err_orphan), 96'(1));
        check("orphan inflight", 96'(inflight),   96'(0));
        repeat (5) @(negedge clk);
        #1;
        check("orphan sticky",  96'(err_orphan),                96'(1));
        check("orphan no resp", 96'(obs_lane.size() - base),    96'(0));

        // Async reset mid-burst with five outstanding
        apply_reset();
        check("reset clears orphan", 96'(err_orphan), 96'(0));
        stall = 1'b1;
        req_valid = 4'b1111;
        repeat (5) @(negedge clk);
        #1 check("midrst inflight pre", 96'(inflight), 96'(5));
        rst = 1'b0;
        #1;
        check("midrst req_ready",   96'(req_ready),   96'(0));
        check("midrst sq_valid_in", 96'(sq_valid_in), 96'(0));
        check("midrst inflight",    96'(inflight),    96'(0));
        check("midrst resp_valid",  96'(resp_valid),  96'(0));
        check("midrst sq_obj_sel",  96'(sq_obj_sel),  96'(0));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        stall = 1'b0;
        base = obs_lane.size();
        @(negedge clk); #1 req_valid = 4'b0001;
        @(negedge clk); #1 req_valid = '0;
        repeat (20) @(negedge clk);
        #1;
        check("post-rst resp count", 96'(obs_lane.size() - base), 96'(1));
        check("post-rst resp lane",  96'(obs_lane[base]),         96'(0));
        check("post-rst resp dist",  96'(obs_dist[base]),         96'(32'h0000_0000));
        check("post-rst inflight",   96'(inflight),               96'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
